// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional odd parity, stop bit,
// with a level SEND/SENT handshake. Define UART_TX_PARITY_EN to include the parity bit.
module uart_tx #(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE     = 19_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SEND,
    input  logic [7:0] DIN,
    output logic       TX,
    output logic       BUSY,
    output logic       SENT
);

    localparam int unsigned BAUD_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CW          = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, BITS, PAR, STOP, ACK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, BITS, STOP, ACK} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            sent_q, sent_d;
    logic            bit_end;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        bit_end = (baud_q == BAUD_LAST);

        // Baud counter only advances while a bit is on the line
        if (state_q == IDLE || state_q == ACK) begin
            baud_d = '0;
        end else begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (SEND) begin
                    state_d = START;
                    shift_d = DIN;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ~^DIN;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = BITS;
            end
            BITS: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = ACK;
            end
            ACK: begin
                if (!SEND) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register on the entering edge
        case (state_d)
            START:   tx_d = 1'b0;
            BITS:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PAR:     tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) && (state_d != ACK);
        sent_d = (state_d == ACK);
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign SENT = sent_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 16 clocks per bit; follows UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int BC = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BC;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SEND = 1'b0;
    logic [7:0] DIN = '0;
    logic       TX, BUSY, SENT;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    bit          expq[$];

    uart_tx #(.CLK_FREQUENCY(16), .BAUD_RATE(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .SEND(SEND),
        .DIN (DIN),
        .TX  (TX),
        .BUSY(BUSY),
        .SENT(SENT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        expq.push_back(1'b0);
        for (int i = 0; i < 8; i++) expq.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        expq.push_back(~^d);
`endif
        expq.push_back(1'b1);
    endtask

    // Sends one byte and checks every bit mid-bit plus SENT latency.
    task automatic run_frame(input logic [7:0] d, input bit chg_din, input bit keep_send);
        int unsigned t0;
        int unsigned off;
        int n;
        bit e;
        @(negedge CLK);
        DIN  = d;
        SEND = 1'b1;
        push_frame(d);
        n = 0;
        while (TX !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (TX !== 1'b0) begin
            check_val("tx_fall_timeout", 32'(TX), 32'd0);
            expq.delete();
            SEND = 1'b0;
            return;
        end
        t0 = cyc;
        check_val("busy_rise", 32'(BUSY), 32'd1);
        off = 0;
        while (off < FRAME + 20 && SENT !== 1'b1) begin
            if (off % BC == BC / 2 && expq.size() > 0) begin
                e = expq.pop_front();
                check_val("tx_bit", 32'(TX), 32'(e));
            end
            if (chg_din && off == 40) DIN = 8'hFF;
            @(negedge CLK);
            off = cyc - t0;
        end
        check_val("sent_latency", off, FRAME);
        check_val("busy_fall", 32'(BUSY), 32'd0);
        check_val("bits_left", expq.size(), 32'd0);
        expq.delete();
        if (!keep_send) begin
            SEND = 1'b0;
            @(negedge CLK);
            check_val("sent_fall", 32'(SENT), 32'd0);
        end
    endtask

    initial begin
        int tx_low;
        int sent_low;
        int busy_hi;
        int n;
        int unsigned t0;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("rst_tx", 32'(TX), 32'd1);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        check_val("rst_sent", 32'(SENT), 32'd0);
        RST = 1'b0;

        run_frame(8'h41, 1'b0, 1'b0);
        run_frame(8'h03, 1'b0, 1'b0);
        run_frame(8'h07, 1'b0, 1'b0);
        run_frame(8'h00, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b0, 1'b0);

        // SEND held after completion: no second frame, SENT stays up
        run_frame(8'h3C, 1'b0, 1'b1);
        tx_low = 0; sent_low = 0; busy_hi = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) tx_low++;
            if (SENT !== 1'b1) sent_low++;
            if (BUSY !== 1'b0) busy_hi++;
        end
        check_val("hold_tx_low", tx_low, 32'd0);
        check_val("hold_sent_low", sent_low, 32'd0);
        check_val("hold_busy_hi", busy_hi, 32'd0);
        SEND = 1'b0;
        @(negedge CLK);
        check_val("hold_sent_fall", 32'(SENT), 32'd0);

        run_frame(8'h55, 1'b1, 1'b0);

        // Reset during data bit 3
        @(negedge CLK);
        DIN  = 8'h55;
        SEND = 1'b1;
        n = 0;
        while (TX !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_val("mid_tx_fall", 32'(TX), 32'd0);
        t0 = cyc;
        while (cyc - t0 < 72) @(negedge CLK);
        check_val("mid_busy", 32'(BUSY), 32'd1);
        RST  = 1'b1;
        SEND = 1'b0;
        @(negedge CLK);
        check_val("mid_rst_tx", 32'(TX), 32'd1);
        check_val("mid_rst_busy", 32'(BUSY), 32'd0);
        check_val("mid_rst_sent", 32'(SENT), 32'd0);
        RST = 1'b0;
        run_frame(8'h96, 1'b0, 1'b0);

        // RST and SEND together: reset wins
        @(negedge CLK);
        RST  = 1'b1;
        SEND = 1'b1;
        @(negedge CLK);
        check_val("rst_send_tx", 32'(TX), 32'd1);
        check_val("rst_send_busy", 32'(BUSY), 32'd0);
        SEND = 1'b0;
        RST  = 1'b0;
        @(negedge CLK);
        check_val("rst_send_idle", 32'(BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
